// File: rtl/p88_loader_if.sv
// Byte-wise ioctl download channel between the image producer (master)
// and the P88 loader (slave); ioctl_wait is the loader's back-pressure.
interface p88_loader_if;
    logic       ioctl_download;
    logic       ioctl_wr;
    logic [7:0] ioctl_dout;
    logic       ioctl_wait;

    modport master (output ioctl_download, ioctl_wr, ioctl_dout, input  ioctl_wait);
    modport slave  (input  ioctl_download, ioctl_wr, ioctl_dout, output ioctl_wait);
endinterface

// File: rtl/p88_loader.sv
// p88_loader: parses a Konix P88 image from the ioctl stream into single-byte DRAM writes.
// Optional feature macro P88_ENTRY_EN: compiles in the 0xCA entry-record path.
module p88_loader #(
    parameter int WRITE_CYCLES = 3
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    p88_loader_if.slave ioctl,
    output logic        hold_reset,
    output logic [19:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_we,
    output logic [15:0] entry_seg,
    output logic [15:0] entry_off,
    output logic        entry_valid,
    output logic        load_error
);
    typedef enum logic [4:0] {
        S_IDLE, S_CMD, S_SEG_L, S_SEG_H, S_OFF_L, S_OFF_H, S_SKIP0, S_SKIP1,
        S_LEN_L, S_LEN_H, S_DATA, S_GAP, S_ESEG_L, S_ESEG_H, S_EOFF_L, S_EOFF_H,
        S_ERROR
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(WRITE_CYCLES - 1);

    state_t      state_q, state_d;
    logic        dl_q;
    logic        hold_q, hold_d;
    logic        err_q, err_d;
    logic [19:0] addr_q, addr_d;
    logic [19:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_data_q, mem_data_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] seg_q, seg_d;
    logic [7:0]  off_lo_q, off_lo_d;
    logic [15:0] len_q, len_d;
    logic [3:0]  cnt_q, cnt_d;

    logic       dl_rise, dl_fall, accept;
    logic [7:0] din;

    assign din     = ioctl.ioctl_dout;
    assign dl_rise = ioctl.ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl.ioctl_download & dl_q;
    // The GAP state is the wait window, so back-pressure drops with the state on reset.
    assign ioctl.ioctl_wait = (state_q == S_GAP);
    assign accept  = ioctl.ioctl_wr & ~ioctl.ioctl_wait & ioctl.ioctl_download;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        err_d      = err_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
        seg_d      = seg_q;
        off_lo_d   = off_lo_q;
        len_d      = len_q;
        cnt_d      = cnt_q;

        if (dl_rise) begin
            state_d  = S_CMD;
            hold_d   = 1'b1;
            err_d    = 1'b0;
            addr_d   = '0;
            seg_d    = '0;
            off_lo_d = '0;
            len_d    = '0;
            cnt_d    = '0;
        end else if (dl_fall) begin
            state_d = S_IDLE;
            hold_d  = 1'b0;
            if (state_q != S_CMD && state_q != S_ERROR) err_d = 1'b1;
        end else if (state_q == S_GAP) begin
            if (cnt_q == GAP_LAST) begin
                addr_d  = addr_q + 20'd1;
                len_d   = len_q - 16'd1;
                state_d = (len_q == 16'd1) ? S_CMD : S_DATA;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else if (accept) begin
            case (state_q)
                S_CMD: begin
                    if (din == 8'hC8) begin
                        state_d = S_SEG_L;
`ifdef P88_ENTRY_EN
                    end else if (din == 8'hCA) begin
                        state_d = S_ESEG_L;
`endif
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
                S_SEG_L: begin seg_d[7:0]  = din; state_d = S_SEG_H; end
                S_SEG_H: begin seg_d[15:8] = din; state_d = S_OFF_L; end
                S_OFF_L: begin off_lo_d    = din; state_d = S_OFF_H; end
                S_OFF_H: begin
                    // Real-mode style segment:offset, wrapping modulo 1 MiB.
                    addr_d  = {seg_q, 4'b0000} + {4'b0000, din, off_lo_q};
                    state_d = S_SKIP0;
                end
                S_SKIP0: state_d = S_SKIP1;
                S_SKIP1: state_d = S_LEN_L;
                S_LEN_L: begin len_d[7:0] = din; state_d = S_LEN_H; end
                S_LEN_H: begin
                    len_d[15:8] = din;
                    state_d     = ({din, len_q[7:0]} == 16'd0) ? S_CMD : S_DATA;
                end
                S_DATA: begin
                    mem_addr_d = addr_q;
                    mem_data_d = din;
                    mem_we_d   = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_GAP;
                end
                S_ESEG_L: state_d = S_ESEG_H;
                S_ESEG_H: state_d = S_EOFF_L;
                S_EOFF_L: state_d = S_EOFF_H;
                S_EOFF_H: state_d = S_CMD;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            dl_q       <= 1'b0;
            hold_q     <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            seg_q      <= '0;
            off_lo_q   <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            dl_q       <= ioctl.ioctl_download;
            hold_q     <= hold_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
            seg_q      <= seg_d;
            off_lo_q   <= off_lo_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
        end
    end

    assign hold_reset = hold_q;
    assign load_error = err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_we     = mem_we_q;

`ifdef P88_ENTRY_EN
    logic [15:0] eseg_q, eseg_d, eoff_q, eoff_d;
    logic        ev_q, ev_d;

    // Entry fields update byte by byte; a later record simply overwrites them.
    always_comb begin
        eseg_d = eseg_q;
        eoff_d = eoff_q;
        ev_d   = ev_q;
        if (dl_rise) begin
            ev_d = 1'b0;
        end else if (accept) begin
            case (state_q)
                S_ESEG_L: eseg_d[7:0]  = din;
                S_ESEG_H: eseg_d[15:8] = din;
                S_EOFF_L: eoff_d[7:0]  = din;
                S_EOFF_H: begin eoff_d[15:8] = din; ev_d = 1'b1; end
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            eseg_q <= '0;
            eoff_q <= '0;
            ev_q   <= 1'b0;
        end else begin
            eseg_q <= eseg_d;
            eoff_q <= eoff_d;
            ev_q   <= ev_d;
        end
    end

    assign entry_seg   = eseg_q;
    assign entry_off   = eoff_q;
    assign entry_valid = ev_q;
`else
    assign entry_seg   = '0;
    assign entry_off   = '0;
    assign entry_valid = 1'b0;
`endif
endmodule

// File: tb/tb_p88_loader.sv
// Self-checking bench for p88_loader: directed scenarios plus random images,
// each checked against a byte-stream parser model of the P88 image format.
module tb_p88_loader;
    localparam int WC = 3;
`ifdef P88_ENTRY_EN
    localparam bit ENTRY_EN = 1'b1;
`else
    localparam bit ENTRY_EN = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        hold_reset, mem_we, entry_valid, load_error;
    logic [19:0] mem_addr;
    logic [7:0]  mem_data;
    logic [15:0] entry_seg, entry_off;

    p88_loader_if ioctl();

    p88_loader #(.WRITE_CYCLES(WC)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ioctl      (ioctl),
        .hold_reset (hold_reset),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .entry_seg  (entry_seg),
        .entry_off  (entry_off),
        .entry_valid(entry_valid),
        .load_error (load_error)
    );

    always #5 clk_sys = ~clk_sys;

    int          errors = 0;
    int          checks = 0;
    bit          inject = 1'b0;
    logic [7:0]  stream_q[$];
    logic [27:0] got_q[$];
    logic [27:0] exp_q[$];
    bit          is_data[512];
    logic [15:0] m_eseg, m_eoff;
    bit          m_ev, m_err;

    always @(negedge clk_sys) if (mem_we === 1'b1) got_q.push_back({mem_addr, mem_data});

    // Reference parser over the first n stream bytes: expected writes, entry, error.
    task automatic model_parse(input int n);
        int i = 0;
        int seg, off, len;
        logic [7:0]  c;
        logic [19:0] a;
        exp_q.delete();
        foreach (is_data[k]) is_data[k] = 1'b0;
        m_err = 1'b0; m_ev = 1'b0; m_eseg = '0; m_eoff = '0;
        while (i < n) begin
            c = stream_q[i];
            i++;
            if (c == 8'hC8) begin
                if (i + 8 > n) begin m_err = 1'b1; break; end
                seg = stream_q[i]   + 256 * stream_q[i+1];
                off = stream_q[i+2] + 256 * stream_q[i+3];
                len = stream_q[i+6] + 256 * stream_q[i+7];
                i += 8;
                a = 20'((seg * 16 + off) % (1 << 20));
                for (int j = 0; j < len; j++) begin
                    if (i >= n) begin m_err = 1'b1; break; end
                    exp_q.push_back({a, stream_q[i]});
                    is_data[i] = 1'b1;
                    a = a + 20'd1;
                    i++;
                end
                if (m_err) break;
            end else if (c == 8'hCA && ENTRY_EN) begin
                if (i + 4 > n) begin m_err = 1'b1; break; end
                m_eseg = 16'(stream_q[i]   + 256 * stream_q[i+1]);
                m_eoff = 16'(stream_q[i+2] + 256 * stream_q[i+3]);
                m_ev   = 1'b1;
                i += 4;
            end else begin
                m_err = 1'b1;
                break;
            end
        end
    endtask

    task automatic add_section(input logic [15:0] seg, input logic [15:0] off, input int len);
        stream_q.push_back(8'hC8);
        stream_q.push_back(seg[7:0]);  stream_q.push_back(seg[15:8]);
        stream_q.push_back(off[7:0]);  stream_q.push_back(off[15:8]);
        stream_q.push_back(8'($urandom)); stream_q.push_back(8'($urandom));
        stream_q.push_back(8'(len));   stream_q.push_back(8'(len >> 8));
        repeat (len) stream_q.push_back(8'($urandom));
    endtask

    task automatic add_entry(input logic [15:0] seg, input logic [15:0] off);
        stream_q.push_back(8'hCA);
        stream_q.push_back(seg[7:0]); stream_q.push_back(seg[15:8]);
        stream_q.push_back(off[7:0]); stream_q.push_back(off[15:8]);
    endtask

    // One strobe, honouring back-pressure; optionally fires a stray strobe into the wait window.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(posedge clk_sys); #1;
        while (ioctl.ioctl_wait !== 1'b0 && t < 100) begin
            @(posedge clk_sys); #1;
            t++;
        end
        if (t >= 100) begin
            errors++; checks++;
            $display("FAIL wait_timeout ioctl_wait=%b required 0", ioctl.ioctl_wait);
        end
        ioctl.ioctl_wr = 1'b1; ioctl.ioctl_dout = b;
        @(posedge clk_sys); #1;
        ioctl.ioctl_wr = 1'b0;
        if (inject && ioctl.ioctl_wait === 1'b1) begin
            ioctl.ioctl_wr = 1'b1; ioctl.ioctl_dout = 8'hEE;
            @(posedge clk_sys); #1;
            ioctl.ioctl_wr = 1'b0;
        end
    endtask

    task automatic run_stream(input string tag, input int n, input bit win_chk);
        int d = 0;
        model_parse(n);
        got_q.delete();
        @(posedge clk_sys); #1;
        ioctl.ioctl_download = 1'b1;
        @(posedge clk_sys); @(negedge clk_sys);
        checks++;
        if (hold_reset !== 1'b1) begin errors++; $display("FAIL %s hold_set got=%b want=1", tag, hold_reset); end
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk_sys);
            send_byte(stream_q[k]);
            if (win_chk && is_data[k]) begin
                for (int w = 1; w <= WC; w++) begin
                    @(negedge clk_sys);
                    checks++;
                    if (ioctl.ioctl_wait !== 1'b1 || mem_we !== (w == 1)) begin
                        errors++;
                        $display("FAIL %s window byte=%0d cyc=%0d wait=%b we=%b want wait=1 we=%b",
                                 tag, k, w, ioctl.ioctl_wait, mem_we, w == 1);
                    end
                    if (w == 1) begin
                        checks++;
                        if ({mem_addr, mem_data} !== exp_q[d]) begin
                            errors++;
                            $display("FAIL %s strobe got=%h/%h want=%h/%h", tag, mem_addr, mem_data,
                                     exp_q[d][27:8], exp_q[d][7:0]);
                        end
                    end
                end
                @(negedge clk_sys);
                checks++;
                if (ioctl.ioctl_wait !== 1'b0) begin
                    errors++; $display("FAIL %s window_end wait=%b want=0", tag, ioctl.ioctl_wait);
                end
                d++;
            end
        end
        repeat (WC + 3) @(posedge clk_sys);
        #1 ioctl.ioctl_download = 1'b0;
        @(negedge clk_sys);
        checks++;
        if (hold_reset !== 1'b1) begin errors++; $display("FAIL %s hold_keep got=%b want=1", tag, hold_reset); end
        @(negedge clk_sys);
        checks++;
        if (hold_reset !== 1'b0) begin errors++; $display("FAIL %s hold_clear got=%b want=0", tag, hold_reset); end
        checks++;
        if (load_error !== m_err) begin errors++; $display("FAIL %s load_error got=%b want=%b", tag, load_error, m_err); end
        checks++;
        if (entry_valid !== m_ev) begin errors++; $display("FAIL %s entry_valid got=%b want=%b", tag, entry_valid, m_ev); end
        if (m_ev || !ENTRY_EN) begin
            checks++;
            if (entry_seg !== m_eseg || entry_off !== m_eoff) begin
                errors++;
                $display("FAIL %s entry got=%h:%h want=%h:%h", tag, entry_seg, entry_off, m_eseg, m_eoff);
            end
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL %s write_count got=%0d want=%0d", tag, got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL %s write[%0d] got=%h/%h want=%h/%h", tag, k, got_q[k][27:8], got_q[k][7:0],
                         exp_q[k][27:8], exp_q[k][7:0]);
            end
        end
        $display("stream %s: %0d bytes, %0d writes, load_error=%b entry_valid=%b",
                 tag, n, got_q.size(), load_error, entry_valid);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        checks++;
        if ({hold_reset, mem_we, ioctl.ioctl_wait, load_error, entry_valid} !== 5'b0 ||
            mem_addr !== 20'h0 || mem_data !== 8'h0 || entry_seg !== 16'h0 || entry_off !== 16'h0) begin
            errors++;
            $display("FAIL reset_state hold=%b we=%b wait=%b err=%b ev=%b addr=%h data=%h es=%h eo=%h want all 0",
                     hold_reset, mem_we, ioctl.ioctl_wait, load_error, entry_valid, mem_addr, mem_data,
                     entry_seg, entry_off);
        end
        @(posedge clk_sys); #1 reset_n = 1'b1;
    endtask

    task automatic test_section();
        stream_q = '{8'hC8, 8'h00, 8'h80, 8'h10, 8'h00, 8'h5A, 8'hA5, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        inject = 1'b0;
        run_stream("section", stream_q.size(), 1'b1);
    endtask

    task automatic test_wrap();
        stream_q.delete();
        add_section(16'hFFFF, 16'h0010, 2);
        run_stream("wrap", stream_q.size(), 1'b1);
    endtask

    task automatic test_zero_entry();
        stream_q.delete();
        add_section(16'h2000, 16'h0004, 0);
        add_entry(16'h1234, 16'h5678);
        run_stream("zero_entry", stream_q.size(), 1'b0);
    endtask

    task automatic test_unknown();
        stream_q.delete();
        stream_q.push_back(8'h55);
        repeat (10) stream_q.push_back(8'($urandom));
        run_stream("unknown", stream_q.size(), 1'b0);
    endtask

    task automatic test_truncation();
        stream_q.delete();
        add_section(16'h0300, 16'h0007, 4);
        run_stream("truncation", 11, 1'b0);
    endtask

    task automatic test_wait_strobe();
        stream_q.delete();
        add_section(16'h4321, 16'h00F0, 5);
        inject = 1'b1;
        run_stream("wait_strobe", stream_q.size(), 1'b0);
        inject = 1'b0;
    endtask

    task automatic test_async_reset();
        stream_q.delete();
        add_section(16'h1000, 16'h0020, 4);
        @(posedge clk_sys); #1 ioctl.ioctl_download = 1'b1;
        repeat (2) @(posedge clk_sys);
        for (int k = 0; k < 10; k++) send_byte(stream_q[k]);
        #1;
        checks++;
        if (mem_we !== 1'b1) begin errors++; $display("FAIL async_pre mem_we=%b want=1", mem_we); end
        reset_n = 1'b0;
        ioctl.ioctl_download = 1'b0;
        #1;
        checks++;
        if ({mem_we, ioctl.ioctl_wait, hold_reset, load_error} !== 4'b0 ||
            mem_addr !== 20'h0 || mem_data !== 8'h0) begin
            errors++;
            $display("FAIL async_reset we=%b wait=%b hold=%b err=%b addr=%h data=%h want all 0",
                     mem_we, ioctl.ioctl_wait, hold_reset, load_error, mem_addr, mem_data);
        end
        $display("stream async_reset: reset asserted during GAP");
        repeat (2) @(posedge clk_sys);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            stream_q.delete();
            repeat ($urandom_range(1, 4)) begin
                case ($urandom_range(0, 9))
                    0:       add_entry(16'($urandom), 16'($urandom));
                    1:       stream_q.push_back(8'($urandom_range(0, 255)));
                    default: add_section(16'($urandom), 16'($urandom), $urandom_range(0, 6));
                endcase
            end
            inject = ($urandom_range(0, 1) == 1);
            run_stream($sformatf("random%0d", it), stream_q.size(), 1'b0);
        end
        inject = 1'b0;
    endtask

    initial begin
        ioctl.ioctl_download = 1'b0;
        ioctl.ioctl_wr       = 1'b0;
        ioctl.ioctl_dout     = 8'h00;
        test_reset();
        test_section();
        test_wrap();
        test_zero_entry();
        test_unknown();
        test_truncation();
        test_section();
        test_wait_strobe();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
